// File: rtl/ir_key_ctrl.sv
// ir_key_ctrl: IR remote command controller feeding the six-digit display.
// Validates 32-bit remote frames, decodes key presses into digit-entry
// actions on a six-digit BCD buffer, commits the buffer on ENTER and clears
// a partial entry after a period of inactivity.
//
// Ports:
//   clk, rst_n          system clock / async active-low reset
//   i_frame[31:0]       {addr, ~addr, cmd, ~cmd}
//   i_frame_vld         one-cycle strobe, sampled only while o_frame_rdy
//   o_frame_rdy         high only in IDLE
//   o_digits[23:0]      BCD entry buffer, [3:0] = most recent digit
//   o_dp[5:0]           thermometer of entered digit count
//   o_commit_vld        one-cycle pulse on ENTER
//   o_commit_val[23:0]  buffer value at the last ENTER
//   o_err_cnt[7:0]      saturating count of rejected frames
module ir_key_ctrl #(
    parameter logic [7:0]  ADDR        = 8'h00,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_frame,
    input  logic        i_frame_vld,
    output logic        o_frame_rdy,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic        o_commit_vld,
    output logic [23:0] o_commit_val,
    output logic [7:0]  o_err_cnt
);

    localparam logic [7:0] CMD_CLEAR = 8'h45;
    localparam logic [7:0] CMD_BACK  = 8'h44;
    localparam logic [7:0] CMD_ENTER = 8'h43;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_frame, w_frame_nxt;
    logic [23:0] r_buf, w_buf_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [5:0]  r_dp, w_dp_nxt;
    logic        r_rdy;
    logic        r_cvld, w_cvld_nxt;
    logic [23:0] r_cval, w_cval_nxt;
    logic [7:0]  r_err, w_err_nxt;
    logic [31:0] r_timer, w_timer_nxt, w_timer_inc;

    logic [7:0]  w_cmd;
    logic        w_pass;
    logic        w_key_vld;
    logic [3:0]  w_key;

    assign w_cmd  = r_frame[15:8];
    assign w_pass = (r_frame[31:24] == ADDR) &&
                    (r_frame[23:16] == ~r_frame[31:24]) &&
                    (r_frame[7:0]   == ~r_frame[15:8]);

    // Remote key codes to BCD digit
    always_comb begin
        w_key_vld = 1'b1;
        w_key     = 4'd0;
        case (w_cmd)
            8'h16:   w_key = 4'd0;
            8'h0C:   w_key = 4'd1;
            8'h18:   w_key = 4'd2;
            8'h5E:   w_key = 4'd3;
            8'h08:   w_key = 4'd4;
            8'h1C:   w_key = 4'd5;
            8'h5A:   w_key = 4'd6;
            8'h42:   w_key = 4'd7;
            8'h52:   w_key = 4'd8;
            8'h4A:   w_key = 4'd9;
            default: w_key_vld = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_cvld_nxt  = 1'b0;
        w_cval_nxt  = r_cval;
        w_err_nxt   = r_err;
        w_timer_inc = (r_timer == TIMEOUT_CYC) ? r_timer : r_timer + 32'd1;
        w_timer_nxt = w_timer_inc;

        case (r_state)
            S_IDLE: begin
                if (i_frame_vld) begin
                    w_frame_nxt = i_frame;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_pass) begin
                    w_state_nxt = S_EXEC;
                    w_timer_nxt = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                    if (r_err != 8'hFF) w_err_nxt = r_err + 8'd1;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_IDLE;
                // a timeout landing on an EXEC cycle is dropped; timer restarts
                if (w_timer_inc == TIMEOUT_CYC) w_timer_nxt = '0;
                if (w_key_vld) begin
                    if (r_cnt != 3'd6) begin
                        w_buf_nxt = {r_buf[19:0], w_key};
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end else begin
                    case (w_cmd)
                        CMD_CLEAR: begin
                            w_buf_nxt = '0;
                            w_cnt_nxt = '0;
                        end
                        CMD_BACK: begin
                            if (r_cnt != 3'd0) begin
                                w_buf_nxt = {4'h0, r_buf[23:4]};
                                w_cnt_nxt = r_cnt - 3'd1;
                            end
                        end
                        CMD_ENTER: begin
                            w_cval_nxt = r_buf;
                            w_cvld_nxt = 1'b1;
                            w_buf_nxt  = '0;
                            w_cnt_nxt  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Timeout fires only on the edge where the timer first reaches the
        // limit; passes and EXEC force the timer to 0 so they never collide.
        if (w_timer_nxt == TIMEOUT_CYC && r_timer != TIMEOUT_CYC && r_cnt != 3'd0) begin
            w_buf_nxt = '0;
            w_cnt_nxt = '0;
        end

        for (int i = 0; i < 6; i++) w_dp_nxt[i] = (w_cnt_nxt > 3'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_frame <= '0;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_dp    <= '0;
            r_rdy   <= 1'b1;
            r_cvld  <= 1'b0;
            r_cval  <= '0;
            r_err   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_frame <= w_frame_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dp    <= w_dp_nxt;
            r_rdy   <= (w_state_nxt == S_IDLE);
            r_cvld  <= w_cvld_nxt;
            r_cval  <= w_cval_nxt;
            r_err   <= w_err_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    assign o_frame_rdy  = r_rdy;
    assign o_digits     = r_buf;
    assign o_dp         = r_dp;
    assign o_commit_vld = r_cvld;
    assign o_commit_val = r_cval;
    assign o_err_cnt    = r_err;

endmodule

// File: doc/ir_key_ctrl.md
# ir_key_ctrl

Command controller between the IR receiver and the six-digit LED display path. It accepts complete 32-bit remote-control frames and validates their address and command checks. It decodes key presses into digit-entry actions and maintains a six-digit BCD entry buffer, which feeds the digit decoders and display multiplexer. Validated ENTER commits the buffer as a one-cycle result pulse; inactivity clears a partial entry.

## Interface
- ADDR, 8'h00: required frame address byte.
- TIMEOUT_CYC, 32'd500_000_000: idle clk cycles before a partial entry is cleared (10 s at 50 MHz); must be >= 2.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- i_frame  in  32  received frame: [31:24] address, [23:16] ~address, [15:8] command, [7:0] ~command.
- i_frame_vld  in  1  one-cycle strobe, i_frame valid.
- o_frame_rdy  out  1  controller can accept a frame this cycle.
- o_digits  out  24  six BCD nibbles, [3:0] = most recently entered (rightmost) digit.
- o_dp  out  6  thermometer of entered count: bit i = 1 when count > i.
- o_commit_vld  out  1  one-cycle pulse on ENTER.
- o_commit_val  out  24  buffer value at ENTER, held until the next commit.
- o_err_cnt  out  8  count of rejected frames, saturating at 255.

## Operation
- States: IDLE, CHECK, EXEC. o_frame_rdy = 1 only in IDLE.
- IDLE: on i_frame_vld, latch i_frame and go to CHECK. A frame presented while o_frame_rdy = 0 is dropped silently; there is no queue.
- CHECK: the frame passes only if address == ADDR, byte[23:16] == ~address and byte[7:0] == ~command.
  - Pass: go to EXEC.
  - Fail: o_err_cnt += 1 (saturating at 255), return to IDLE, buffer untouched.
- EXEC: act on the command byte, then return to IDLE. Internal count is 0..6.
  - Digit keys: 0=8'h16, 1=8'h0C, 2=8'h18, 3=8'h5E, 4=8'h08, 5=8'h1C, 6=8'h5A, 7=8'h42, 8=8'h52, 9=8'h4A.
    - If count < 6: buffer <= {buffer[19:0], d}, count += 1.
    - If count == 6: digit ignored.
  - CLEAR 8'h45: buffer = 0, count = 0.
  - BACK 8'h44: buffer <= {4'h0, buffer[23:4]}, count -= 1. No-op at count 0.
  - ENTER 8'h43: o_commit_val <= buffer, o_commit_vld pulses, then buffer = 0, count = 0. ENTER at count 0 still commits 24'h0.
  - Any other command: no action, not an error.
- Inactivity timer:
  - Cleared to 0 by every frame that passes CHECK; otherwise increments each cycle, saturating at TIMEOUT_CYC.
  - When it reaches TIMEOUT_CYC with count != 0: buffer and count are cleared once. No commit pulse.
  - If timeout and EXEC occur in the same cycle, EXEC wins and the timer restarts.
- o_dp is derived from the registered count; all outputs are registered.

## Timing
- Reset values: state IDLE, o_frame_rdy 1, o_digits 0, o_dp 0, o_commit_vld 0, o_commit_val 0, o_err_cnt 0, timer 0.
- Frame accepted at edge N (vld & rdy):
  - CHECK at cycle N+1, EXEC at N+2.
  - o_digits, o_dp and o_commit_* are updated at edge N+3.
  - o_frame_rdy is low for cycles N+1..N+2 (rejected frame: N+1 only) and high again at N+3 (rejected: N+2).
- o_commit_vld is high for exactly one cycle. In that cycle o_digits already reads 0.
- o_err_cnt updates at edge N+2 for a rejected frame.
- Minimum accepted frame spacing is 3 cycles. Back-to-back vld during busy cycles is dropped.
- rst_n asserted mid-operation returns to IDLE immediately, discards the latched frame and produces no commit.

## Test plan
- Frames 32'h00FF0CF3, 32'h00FF18E7, 32'h00FF5EA1 (keys 1, 2, 3), 4-cycle spacing -> o_digits = 24'h000123, o_dp = 6'b000111.
- Then 32'h00FF43BC (ENTER) -> o_commit_vld pulses once with o_commit_val = 24'h000123; o_digits = 0, o_dp = 0 in the same cycle.
- Seven key-1 frames, then 32'h00FF44BB (BACK) -> o_digits = 24'h111111 after six, unchanged after the seventh, 24'h011111 with o_dp = 6'b011111 after BACK.
- Rejected and dropped frames:
  - 32'h00FF0C00 (bad ~command) and 32'h01FE0CF3 (wrong address) -> o_err_cnt = 2, o_digits unchanged.
  - A vld asserted one cycle after an accepted frame is ignored.
- TIMEOUT_CYC = 100: key 5 (32'h00FF1CE3), then idle -> o_digits = 24'h000005 until cycle 100 after its CHECK, then 0; no commit pulse.
- Reset mid-op and saturation:
  - Assert rst_n low during EXEC of ENTER -> all outputs return to reset values, no commit pulse.
  - 300 rejected frames -> o_err_cnt = 255.
